// File: rtl/nvm_read_pkg.sv
// Shared constants and helpers for the NVM read-side hard-decision path.
package nvm_read_pkg;

  localparam int unsigned DEF_CELLS_PER_WORD = 16;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned LEVEL_W            = 2;
  localparam int unsigned NUM_LEVELS         = 4;

  typedef logic [LEVEL_W-1:0] level_t;

  localparam level_t GRAY_L0 = 2'b11;
  localparam level_t GRAY_L1 = 2'b10;
  localparam level_t GRAY_L2 = 2'b00;
  localparam level_t GRAY_L3 = 2'b01;

  // Adjacent levels differ in one bit so a one-level misread costs one bit error.
  function automatic level_t level_to_gray(input level_t lvl);
    case (lvl)
      2'd0:    return GRAY_L0;
      2'd1:    return GRAY_L1;
      2'd2:    return GRAY_L2;
      default: return GRAY_L3;
    endcase
  endfunction

endpackage

// File: rtl/vth_level_slicer.sv
// Stage 1: slices a signed cell voltage against three read references.
module vth_level_slicer
  import nvm_read_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_voltage,
  input  logic signed [DATA_W-1:0] ref0,
  input  logic signed [DATA_W-1:0] ref1,
  input  logic signed [DATA_W-1:0] ref2,
  output logic                     cell_valid,
  output level_t                   cell_level
);

  logic   ge0, ge1, ge2;
  level_t level_c;

  // Counting passed refs keeps the result defined for any reference ordering.
  assign ge0     = (in_voltage >= ref0);
  assign ge1     = (in_voltage >= ref1);
  assign ge2     = (in_voltage >= ref2);
  assign level_c = LEVEL_W'(ge0) + LEVEL_W'(ge1) + LEVEL_W'(ge2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cell_valid <= 1'b0;
      cell_level <= '0;
    end else begin
      cell_valid <= in_valid;
      if (in_valid) cell_level <= level_c;
    end
  end

endmodule

// File: rtl/vth_read_detector.sv
// Hard-decision read detector: level slicing, Gray word packing and
// per-level occupancy histograms.
module vth_read_detector
  import nvm_read_pkg::*;
#(
  parameter int unsigned CELLS_PER_WORD = DEF_CELLS_PER_WORD,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic signed [DATA_W-1:0]         in_voltage,
  input  logic signed [DATA_W-1:0]         ref0,
  input  logic signed [DATA_W-1:0]         ref1,
  input  logic signed [DATA_W-1:0]         ref2,
  input  logic                             resync,
  input  logic                             clear_stats,
  output logic                             cell_valid,
  output logic [1:0]                       cell_level,
  output logic                             word_valid,
  output logic [2*CELLS_PER_WORD-1:0]      level_word,
  output logic [CNT_W-1:0]                 hist0,
  output logic [CNT_W-1:0]                 hist1,
  output logic [CNT_W-1:0]                 hist2,
  output logic [CNT_W-1:0]                 hist3
);

  localparam int unsigned IDX_W  = $clog2(CELLS_PER_WORD);
  localparam int unsigned WORD_W = LEVEL_W * CELLS_PER_WORD;
  localparam int unsigned LAST   = CELLS_PER_WORD - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0]  index;
  logic [IDX_W-1:0]  idx_eff;
  logic [WORD_W-1:0] shadow;
  logic [WORD_W-1:0] shadow_next;
  logic              last_c;
  level_t            gray_c;
  logic [CNT_W-1:0]  hist [NUM_LEVELS];

  vth_level_slicer #(.DATA_W(DATA_W)) u_slicer (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_voltage (in_voltage),
    .ref0       (ref0),
    .ref1       (ref1),
    .ref2       (ref2),
    .cell_valid (cell_valid),
    .cell_level (cell_level)
  );

  // A resync arriving with a cell places that cell at index 0.
  assign idx_eff = resync ? '0 : index;
  assign gray_c  = level_to_gray(cell_level);
  assign last_c  = cell_valid && (idx_eff == IDX_W'(LAST));

  always_comb begin
    shadow_next = shadow;
    for (int k = 0; k < int'(CELLS_PER_WORD); k++) begin
      if (cell_valid && (idx_eff == IDX_W'(k))) shadow_next[LEVEL_W*k +: LEVEL_W] = gray_c;
    end
  end

  // Packer: shadow bits are never cleared, only overwritten by later cells.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index      <= '0;
      shadow     <= '0;
      level_word <= '0;
      word_valid <= 1'b0;
    end else begin
      shadow     <= shadow_next;
      word_valid <= last_c;
      if (last_c) level_word <= shadow_next;
      if (cell_valid) index <= last_c ? '0 : idx_eff + IDX_W'(1);
      else if (resync) index <= '0;
    end
  end

  // Saturating occupancy counters; a clear drops any same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < int'(NUM_LEVELS); l++) hist[l] <= '0;
    end else if (clear_stats) begin
      for (int l = 0; l < int'(NUM_LEVELS); l++) hist[l] <= '0;
    end else if (cell_valid && (hist[cell_level] != CNT_MAX)) begin
      hist[cell_level] <= hist[cell_level] + CNT_W'(1);
    end
  end

  assign hist0 = hist[0];
  assign hist1 = hist[1];
  assign hist2 = hist[2];
  assign hist3 = hist[3];

endmodule

// File: tb/tb_vth_read_detector.sv
// Directed scoreboard bench for vth_read_detector (16-bit and 4-bit counter builds).
module tb_vth_read_detector;

  localparam int unsigned CPW = 16;
  localparam int unsigned DW  = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic signed [DW-1:0] in_voltage;
  logic signed [DW-1:0] ref0, ref1, ref2;
  logic                 resync;
  logic                 clear_stats;

  logic          cell_valid, word_valid;
  logic [1:0]    cell_level;
  logic [31:0]   level_word;
  logic [15:0]   hist0, hist1, hist2, hist3;

  logic          c4_cell_valid, c4_word_valid;
  logic [1:0]    c4_cell_level;
  logic [31:0]   c4_level_word;
  logic [3:0]    c4_hist0, c4_hist1, c4_hist2, c4_hist3;

  vth_read_detector #(.CELLS_PER_WORD(CPW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_voltage(in_voltage),
    .ref0(ref0), .ref1(ref1), .ref2(ref2), .resync(resync), .clear_stats(clear_stats),
    .cell_valid(cell_valid), .cell_level(cell_level), .word_valid(word_valid),
    .level_word(level_word), .hist0(hist0), .hist1(hist1), .hist2(hist2), .hist3(hist3)
  );

  vth_read_detector #(.CELLS_PER_WORD(CPW), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_voltage(in_voltage),
    .ref0(ref0), .ref1(ref1), .ref2(ref2), .resync(resync), .clear_stats(clear_stats),
    .cell_valid(c4_cell_valid), .cell_level(c4_cell_level), .word_valid(c4_word_valid),
    .level_word(c4_level_word), .hist0(c4_hist0), .hist1(c4_hist1), .hist2(c4_hist2),
    .hist3(c4_hist3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        s1_v;
  logic [1:0]  s1_l;
  int          sb_idx;
  logic [31:0] sb_word;
  logic [31:0] last_word;
  logic [31:0] word1;
  logic [31:0] sb_q[$];
  int          due[$];
  int          mh16[4];
  int          mh4[4];
  int          cyc;
  int          wv_count;

  function automatic logic [1:0] ref_level(input logic signed [DW-1:0] v,
                                           input logic signed [DW-1:0] r0,
                                           input logic signed [DW-1:0] r1,
                                           input logic signed [DW-1:0] r2);
    int n;
    n = 0;
    if (v >= r0) n++;
    if (v >= r1) n++;
    if (v >= r2) n++;
    return 2'(n);
  endfunction

  function automatic logic [1:0] gray_of(input logic [1:0] l);
    case (l)
      2'd0:    return 2'b11;
      2'd1:    return 2'b10;
      2'd2:    return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic exp_wv);
    chk("cell_valid", 64'(cell_valid), 64'(s1_v));
    if (s1_v) chk("cell_level", 64'(cell_level), 64'(s1_l));
    chk("word_valid", 64'(word_valid), 64'(exp_wv));
    chk("level_word", 64'(level_word), 64'(last_word));
    chk("c4_level_word", 64'(c4_level_word), 64'(last_word));
    chk("hist0", 64'(hist0), 64'(mh16[0]));
    chk("hist1", 64'(hist1), 64'(mh16[1]));
    chk("hist2", 64'(hist2), 64'(mh16[2]));
    chk("hist3", 64'(hist3), 64'(mh16[3]));
    chk("c4_hist0", 64'(c4_hist0), 64'(mh4[0]));
    chk("c4_hist1", 64'(c4_hist1), 64'(mh4[1]));
    chk("c4_hist2", 64'(c4_hist2), 64'(mh4[2]));
    chk("c4_hist3", 64'(c4_hist3), 64'(mh4[3]));
  endtask

  // One clock: drive inputs, advance reference model, sample 1ns after the edge.
  task automatic tick(input logic v, input logic signed [DW-1:0] volt,
                      input logic rs, input logic cs);
    logic       exp_wv;
    logic [1:0] lv;
    int         k;
    in_valid    = v;
    in_voltage  = volt;
    resync      = rs;
    clear_stats = cs;
    lv = ref_level(volt, ref0, ref1, ref2);
    @(posedge clk);
    if (cs) begin
      for (int i = 0; i < 4; i++) begin mh16[i] = 0; mh4[i] = 0; end
    end else if (s1_v) begin
      if (mh16[s1_l] < 65535) mh16[s1_l]++;
      if (mh4[s1_l] < 15) mh4[s1_l]++;
    end
    exp_wv = 1'b0;
    if (due.size() > 0 && due[0] == cyc) begin
      void'(due.pop_front());
      exp_wv = 1'b1;
      if (sb_q.size() > 0) last_word = sb_q.pop_front();
    end
    s1_v = v;
    if (v) s1_l = lv;
    if (v) begin
      k = rs ? 0 : sb_idx;
      sb_word[2*k +: 2] = gray_of(lv);
      if (k == CPW - 1) begin
        sb_q.push_back(sb_word);
        due.push_back(cyc + 1);
        sb_idx = 0;
      end else begin
        sb_idx = k + 1;
      end
    end else if (rs) begin
      sb_idx = 0;
    end
    cyc++;
    #1;
    check_outputs(exp_wv);
    if (word_valid) wv_count++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    s1_v = 1'b0; s1_l = '0; sb_idx = 0; sb_word = '0; last_word = '0;
    sb_q.delete(); due.delete();
    for (int i = 0; i < 4; i++) begin mh16[i] = 0; mh4[i] = 0; end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cell_valid"}, 64'(cell_valid), 64'(0));
    chk({tag, "_cell_level"}, 64'(cell_level), 64'(0));
    chk({tag, "_word_valid"}, 64'(word_valid), 64'(0));
    chk({tag, "_level_word"}, 64'(level_word), 64'(0));
    chk({tag, "_hist_or"}, 64'(hist0 | hist1 | hist2 | hist3), 64'(0));
    chk({tag, "_c4_hist_or"}, 64'(c4_hist0 | c4_hist1 | c4_hist2 | c4_hist3), 64'(0));
  endtask

  logic signed [DW-1:0] t1_volt[16];
  logic signed [DW-1:0] rv;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_voltage = '0; resync = 1'b0; clear_stats = 1'b0;
    ref0 = -32'sd100; ref1 = 32'sd0; ref2 = 32'sd100;
    model_reset();
    cyc = 0; wv_count = 0;
    @(posedge clk); #1;
    check_all_zero("reset");
    @(negedge clk); reset = 1'b0;

    // Directed word: levels 0,1,2,2,3,3 then ten cells at level 2.
    t1_volt[0] = -32'sd200; t1_volt[1] = -32'sd1; t1_volt[2] = 32'sd0;
    t1_volt[3] = 32'sd99;   t1_volt[4] = 32'sd100; t1_volt[5] = 32'sd500;
    for (int i = 6; i < 16; i++) t1_volt[i] = 32'sd50;
    for (int i = 0; i < 16; i++) tick(1'b1, t1_volt[i], 1'b0, 1'b0);
    idle(3);
    chk("t1_word", 64'(level_word), 64'(32'h0000_050B));
    chk("t1_h0", 64'(hist0), 64'(1));
    chk("t1_h1", 64'(hist1), 64'(1));
    chk("t1_h2", 64'(hist2), 64'(12));
    chk("t1_h3", 64'(hist3), 64'(2));
    word1 = last_word;

    // 64 back-to-back cells; refs change mid-stream to an unordered set.
    wv_count = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 40) begin ref0 = 32'sd50; ref1 = -32'sd50; ref2 = 32'sd200; end
      rv = 32'($urandom_range(0, 800)) - 32'sd400;
      tick(1'b1, rv, 1'b0, 1'b0);
    end
    idle(3);
    chk("burst_pulses", 64'(wv_count), 64'(4));
    ref0 = -32'sd100; ref1 = 32'sd0; ref2 = 32'sd100;

    // Gapped input, one cell every third cycle.
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, t1_volt[i], 1'b0, 1'b0);
      idle(2);
    end
    idle(1);
    chk("gapped_word", 64'(level_word), 64'(word1));

    // Partial word abandoned by resync.
    wv_count = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, 32'sd500, 1'b0, 1'b0);
    idle(1);
    tick(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rv = 32'($urandom_range(0, 400)) - 32'sd200;
      tick(1'b1, rv, 1'b0, 1'b0);
    end
    idle(3);
    chk("resync_pulses", 64'(wv_count), 64'(1));

    // Saturation of the 4-bit counters, then clear racing an increment.
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b1, 32'sd500, 1'b0, 1'b0);
    idle(2);
    chk("sat_c4_h3", 64'(c4_hist3), 64'(15));
    chk("sat_h3", 64'(hist3), 64'(20));
    tick(1'b1, -32'sd200, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("clr_h_or", 64'(hist0 | hist1 | hist2 | hist3), 64'(0));
    chk("clr_c4_h_or", 64'(c4_hist0 | c4_hist1 | c4_hist2 | c4_hist3), 64'(0));
    idle(2);

    // Asynchronous reset mid-word, then a clean word.
    for (int i = 0; i < 7; i++) tick(1'b1, 32'sd150, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_all_zero("midreset");
    model_reset();
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    wv_count = 0;
    for (int i = 0; i < 16; i++) tick(1'b1, t1_volt[15 - i], 1'b0, 1'b0);
    idle(3);
    chk("postreset_pulses", 64'(wv_count), 64'(1));
    chk("postreset_h2", 64'(hist2), 64'(12));
    chk("pending_due", 64'(due.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
